// File: rtl/memory_access.sv
// rtl/memory_access.sv - RV32I load/store unit bridging the execute stage to a req/gnt/rvalid data bus
module memory_access #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [31:0] instr,
    input  logic [31:0] exec_result,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic        misaligned_err,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    // Count value seen on the edge that closes the last allowed REQ/WAIT cycle
    localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [15:0] timeout_cnt;
    logic [2:0]  op_funct3;
    logic [1:0]  op_lane;
    logic        op_store;

    logic [2:0]  funct3;
    logic        is_load;
    logic        is_store;
    logic        misaligned;
    logic [3:0]  strb_next;
    logic [31:0] wdata_next;
    logic        bus_done;
    logic        unused_instr_bits;

    assign funct3            = instr[14:12];
    assign unused_instr_bits = ^{instr[31:15], instr[11:7]};

    // Sign/zero-extended load value from the lane the access targeted
    function automatic logic [31:0] load_value(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  lane);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = word >> {lane, 3'b000};
        b       = shifted[7:0];
        h       = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  load_value = {{24{b[7]}}, b};
            3'b001:  load_value = {{16{h[15]}}, h};
            3'b100:  load_value = {24'd0, b};
            3'b101:  load_value = {16'd0, h};
            default: load_value = word;
        endcase
    endfunction

    // Decode the presented op: class, alignment, and store lane enables/data
    always_comb begin
        is_load    = (instr[6:0] == 7'b0000011) &&
                     (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010 ||
                      funct3 == 3'b100 || funct3 == 3'b101);
        is_store   = (instr[6:0] == 7'b0100011) &&
                     (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010);
        misaligned = 1'b0;
        strb_next  = 4'b0000;
        wdata_next = 32'd0;
        case (funct3[1:0])
            2'b01:   misaligned = exec_result[0];
            2'b10:   misaligned = (exec_result[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        if (is_store) begin
            case (funct3[1:0])
                2'b00: begin
                    strb_next  = 4'b0001 << exec_result[1:0];
                    wdata_next = {4{store_data[7:0]}};
                end
                2'b01: begin
                    strb_next  = exec_result[1] ? 4'b1100 : 4'b0011;
                    wdata_next = {2{store_data[15:0]}};
                end
                default: begin
                    strb_next  = 4'b1111;
                    wdata_next = store_data;
                end
            endcase
        end
    end

    // Response arrives with the grant in REQ, or on its own in WAIT; rvalid alone in REQ is stray
    assign bus_done = mem_rvalid && ((state == WAIT) || (state == REQ && mem_gnt));

    // Op sequencing with every output registered; pulses default low each cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            timeout_cnt    <= 16'd0;
            op_funct3      <= 3'd0;
            op_lane        <= 2'd0;
            op_store       <= 1'b0;
            stall          <= 1'b0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= 32'd0;
            mem_wstrb      <= 4'd0;
            mem_wdata      <= 32'd0;
            wb_valid       <= 1'b0;
            wb_data        <= 32'd0;
            misaligned_err <= 1'b0;
            bus_err        <= 1'b0;
        end else begin
            wb_valid       <= 1'b0;
            misaligned_err <= 1'b0;
            bus_err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        if (!(is_load || is_store)) begin
                            wb_valid <= 1'b1;
                            wb_data  <= exec_result;
                        end else if (misaligned) begin
                            wb_valid       <= 1'b1;
                            misaligned_err <= 1'b1;
                            wb_data        <= 32'd0;
                        end else begin
                            state       <= REQ;
                            stall       <= 1'b1;
                            mem_req     <= 1'b1;
                            mem_we      <= is_store;
                            mem_addr    <= {exec_result[31:2], 2'b00};
                            mem_wstrb   <= strb_next;
                            mem_wdata   <= wdata_next;
                            op_funct3   <= funct3;
                            op_lane     <= exec_result[1:0];
                            op_store    <= is_store;
                            timeout_cnt <= 16'd0;
                        end
                    end
                end
                REQ, WAIT: begin
                    if (bus_done) begin
                        state    <= RESP;
                        stall    <= 1'b0;
                        mem_req  <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_data  <= op_store ? 32'd0 : load_value(mem_rdata, op_funct3, op_lane);
                    end else if (timeout_cnt == LAST_CNT) begin
                        state    <= RESP;
                        stall    <= 1'b0;
                        mem_req  <= 1'b0;
                        wb_valid <= 1'b1;
                        bus_err  <= 1'b1;
                        wb_data  <= 32'd0;
                    end else begin
                        timeout_cnt <= timeout_cnt + 16'd1;
                        if (state == REQ && mem_gnt) begin
                            state   <= WAIT;
                            mem_req <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// tb/tb_memory_access.sv - directed and randomized checks of memory_access against a behavioural model
module tb_memory_access;

    localparam int TMO = 8;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [31:0] instr;
    logic [31:0] exec_result;
    logic [31:0] store_data;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic        misaligned_err;
    logic        bus_err;

    int          checks;
    int          errors;
    int          req_cycles;
    logic [31:0] last_wb;
    logic [31:0] last_wdata;
    logic [3:0]  last_wstrb;
    logic        last_bus_err;

    logic [31:0] r_ins;
    logic [6:0]  r_op;
    logic [2:0]  r_f3;
    int          r_gd;
    int          r_rd;

    memory_access #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .valid_in       (valid_in),
        .instr          (instr),
        .exec_result    (exec_result),
        .store_data     (store_data),
        .stall          (stall),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wstrb      (mem_wstrb),
        .mem_wdata      (mem_wdata),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .wb_valid       (wb_valid),
        .wb_data        (wb_data),
        .misaligned_err (misaligned_err),
        .bus_err        (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One op from presentation to the cycle after its writeback; gd = REQ cycles before grant,
    // rd = cycles from grant to rvalid (0 = same cycle)
    task automatic run_op(input logic [31:0] ins, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] rdata, input int gd, input int rd);
        logic [2:0]  f3;
        logic        ld, st, mis, tmo;
        int          sz, lane, gcyc, dcyc, wcyc;
        logic [31:0] b, h, exp_wb, exp_wdata;
        logic [3:0]  exp_strb;
        f3   = ins[14:12];
        ld   = (ins[6:0] == 7'h03) && (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        st   = (ins[6:0] == 7'h23) && (f3 <= 2);
        sz   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        lane = int'(addr % 32'd4);
        mis  = (ld || st) && ((addr % 32'(sz)) != 0);
        b    = (rdata >> (8 * lane)) & 32'hFF;
        h    = (rdata >> (16 * (lane / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    exp_wb = (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1:    exp_wb = (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    exp_wb = b;
            3'd5:    exp_wb = h;
            default: exp_wb = rdata;
        endcase
        if (!st)          begin exp_strb = 4'h0;               exp_wdata = sdata; end
        else if (sz == 1) begin exp_strb = 4'(1 << lane);      exp_wdata = (sdata & 32'hFF) * 32'h0101_0101; end
        else if (sz == 2) begin exp_strb = (lane >= 2) ? 4'hC : 4'h3; exp_wdata = (sdata & 32'hFFFF) * 32'h0001_0001; end
        else              begin exp_strb = 4'hF;               exp_wdata = sdata; end

        check("stall_before_op", stall, 0);
        valid_in    = 1'b1;
        instr       = ins;
        exec_result = addr;
        store_data  = sdata;
        step();
        valid_in    = 1'b0;
        instr       = $urandom;
        exec_result = $urandom;
        store_data  = $urandom;

        if (!(ld || st) || mis) begin
            check("direct_wb_valid", wb_valid, 1);
            check("direct_misaligned", misaligned_err, 32'(mis));
            check("direct_bus_err", bus_err, 0);
            check("direct_wb_data", wb_data, mis ? 32'd0 : addr);
            check("direct_no_req", mem_req, 0);
            check("direct_stall", stall, 0);
            last_wb = wb_data;
            step();
            check("direct_wb_pulse_end", wb_valid, 0);
            check("direct_mis_pulse_end", misaligned_err, 0);
        end else begin
            gcyc       = gd + 1;
            dcyc       = gcyc + rd;
            tmo        = (dcyc > TMO);
            wcyc       = (tmo ? TMO : dcyc) + 1;
            req_cycles = 0;
            for (int k = 1; k < wcyc; k++) begin
                check("busy_stall", stall, 1);
                check("busy_no_wb", wb_valid, 0);
                check("busy_mem_req", mem_req, 32'(k <= gcyc));
                if (mem_req) req_cycles++;
                if (k <= gcyc) begin
                    check("req_addr", mem_addr, addr & 32'hFFFF_FFFC);
                    check("req_we", mem_we, 32'(st));
                    check("req_wstrb", mem_wstrb, exp_strb);
                    if (st) check("req_wdata", mem_wdata, exp_wdata);
                end
                if (k == 1) begin
                    last_wstrb = mem_wstrb;
                    last_wdata = mem_wdata;
                end
                mem_gnt    = (k == gcyc);
                mem_rvalid = (k == dcyc) || (k < gcyc && ($urandom % 2) == 1);
                mem_rdata  = (k == dcyc) ? rdata : $urandom;
                step();
            end
            mem_gnt    = 1'b0;
            mem_rvalid = ($urandom % 2) == 1;
            mem_rdata  = $urandom;
            check("resp_wb_valid", wb_valid, 1);
            check("resp_bus_err", bus_err, 32'(tmo));
            check("resp_misaligned", misaligned_err, 0);
            check("resp_stall", stall, 0);
            check("resp_no_req", mem_req, 0);
            check("resp_wb_data", wb_data, (st || tmo) ? 32'd0 : exp_wb);
            last_wb      = wb_data;
            last_bus_err = bus_err;
            step();
            mem_rvalid = 1'b0;
            check("after_wb_valid", wb_valid, 0);
            check("after_bus_err", bus_err, 0);
            check("after_stall", stall, 0);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b0;
        valid_in    = 1'b0;
        instr       = 32'd0;
        exec_result = 32'd0;
        store_data  = 32'd0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = 32'd0;
        repeat (2) step();
        check("rst_stall", stall, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_data", wb_data, 0);
        rst = 1'b1;
        step();

        // addi returning exec_result directly
        run_op(32'h0550_0093, 32'h0000_0055, 32'd0, 32'd0, 0, 0);
        check("addi_wb", last_wb, 32'h0000_0055);

        // lb from the top byte lane, sign extended
        run_op(32'h0000_8083, 32'h0000_1003, 32'h0, 32'h80FF_FF12, 0, 1);
        check("lb_wb", last_wb, 32'hFFFF_FF80);
        check("lb_wstrb", last_wstrb, 4'h0);

        // sh to the upper half with a three-cycle request
        run_op(32'h0020_9023, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 2, 1);
        check("sh_req_cycles", req_cycles, 3);
        check("sh_wstrb", last_wstrb, 4'hC);
        check("sh_wdata", last_wdata, 32'hABCD_ABCD);
        check("sh_wb", last_wb, 32'd0);

        // misaligned lw
        run_op(32'h0000_A083, 32'h0000_3001, 32'h0, 32'h0, 0, 0);
        check("lw_mis_wb", last_wb, 32'd0);

        // lw granted but never acknowledged
        run_op(32'h0000_A083, 32'h0000_6000, 32'h0, 32'h0, 0, 20);
        check("lw_tmo_bus_err", last_bus_err, 1);

        // reset during WAIT, then a stray rvalid
        check("pre_rst_stall", stall, 0);
        valid_in    = 1'b1;
        instr       = 32'h0000_A083;
        exec_result = 32'h0000_4000;
        step();
        valid_in    = 1'b0;
        mem_gnt     = 1'b1;
        step();
        mem_gnt     = 1'b0;
        check("wait_stall", stall, 1);
        #2 rst = 1'b0;
        #1;
        check("arst_stall", stall, 0);
        check("arst_mem_req", mem_req, 0);
        check("arst_mem_we", mem_we, 0);
        check("arst_mem_addr", mem_addr, 0);
        check("arst_mem_wstrb", mem_wstrb, 0);
        check("arst_mem_wdata", mem_wdata, 0);
        check("arst_wb_valid", wb_valid, 0);
        check("arst_wb_data", wb_data, 0);
        check("arst_misaligned", misaligned_err, 0);
        check("arst_bus_err", bus_err, 0);
        step();
        rst        = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        step();
        mem_rvalid = 1'b0;
        check("post_rst_no_wb", wb_valid, 0);
        check("post_rst_stall", stall, 0);
        step();
        check("post_rst_no_wb2", wb_valid, 0);
        run_op(32'h0000_A083, 32'h0000_5004, 32'h0, 32'hCAFE_F00D, 1, 2);
        check("post_rst_lw_wb", last_wb, 32'hCAFE_F00D);

        // randomized ops across all classes, alignments and bus timings
        for (int n = 0; n < 60; n++) begin
            case ($urandom % 4)
                0: begin
                    r_op = 7'h03;
                    case ($urandom % 5)
                        0:       r_f3 = 3'd0;
                        1:       r_f3 = 3'd1;
                        2:       r_f3 = 3'd2;
                        3:       r_f3 = 3'd4;
                        default: r_f3 = 3'd5;
                    endcase
                end
                1: begin
                    r_op = 7'h23;
                    r_f3 = 3'($urandom % 3);
                end
                2: begin
                    if (($urandom % 2) == 1) begin
                        r_op = 7'h03;
                        case ($urandom % 3)
                            0:       r_f3 = 3'd3;
                            1:       r_f3 = 3'd6;
                            default: r_f3 = 3'd7;
                        endcase
                    end else begin
                        r_op = 7'h23;
                        r_f3 = 3'(3 + $urandom % 5);
                    end
                end
                default: begin
                    r_op = (($urandom % 2) == 1) ? 7'h13 : 7'h33;
                    r_f3 = 3'($urandom);
                end
            endcase
            r_ins        = $urandom;
            r_ins[6:0]   = r_op;
            r_ins[14:12] = r_f3;
            r_gd         = int'($urandom % 4);
            r_rd         = (($urandom % 5) == 0) ? int'(6 + $urandom % 4) : int'($urandom % 4);
            run_op(r_ins, $urandom, $urandom, $urandom, r_gd, r_rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
